// File: rtl/demux4_onehot.sv
// demux4_onehot: 1-to-4 stream distributor with a valid/ready handshake.
// Each accepted input word is steered into one of four registered output lanes.
// The lane is picked by a one-hot steer input, where the lowest set bit wins.
// When the steer input is zero, an internal round-robin pointer picks the lane.
// A stalled word waits at the input. It never falls back to another lane.
module demux4_onehot #(
    parameter int K = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [K-1:0] in_data,
    input  logic [3:0]   s,
    output logic [3:0]   out_valid,
    input  logic [3:0]   out_ready,
    output logic [K-1:0] out_data0,
    output logic [K-1:0] out_data1,
    output logic [K-1:0] out_data2,
    output logic [K-1:0] out_data3,
    output logic [3:0]   cur_sel
);

    logic [3:0]   ptr;
    logic [3:0]   target;
    logic [3:0]   free;
    logic [3:0]   load;
    logic         xfer;
    logic [K-1:0] lane_data [4];

    // Target decode: lowest set steer bit wins; all-zero steer defers to the pointer
    always_comb begin
        target = ptr;
        if (s[0])      target = 4'b0001;
        else if (s[1]) target = 4'b0010;
        else if (s[2]) target = 4'b0100;
        else if (s[3]) target = 4'b1000;
    end

    // A lane can take a word if it is empty or is being drained this cycle
    always_comb begin
        free     = ~out_valid | out_ready;
        in_ready = |(free & target);
        xfer     = in_valid & in_ready;
        load     = xfer ? target : 4'b0000;
    end

    assign cur_sel   = target;
    assign out_data0 = lane_data[0];
    assign out_data1 = lane_data[1];
    assign out_data2 = lane_data[2];
    assign out_data3 = lane_data[3];

    // Lane registers: a load wins over a drain, so back-to-back words to one lane leave no bubble
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 4'b0000;
            for (int i = 0; i < 4; i++) begin
                lane_data[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (load[i]) begin
                    out_valid[i] <= 1'b1;
                    lane_data[i] <= in_data;
                end else if (out_ready[i]) begin
                    out_valid[i] <= 1'b0;
                end
            end
        end
    end

    // Round-robin pointer: advances only on a transfer made in round-robin mode
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr <= 4'b0001;
        end else if (xfer && (s == 4'b0000)) begin
            ptr <= {ptr[2:0], ptr[3]};
        end
    end

endmodule

// File: tb/tb_demux4_onehot.sv
// Directed bench for demux4_onehot with K=8 and hand-computed expectations.
module tb_demux4_onehot;

    localparam int K = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [K-1:0] in_data;
    logic [3:0]   s;
    logic [3:0]   out_valid;
    logic [3:0]   out_ready;
    logic [K-1:0] out_data0;
    logic [K-1:0] out_data1;
    logic [K-1:0] out_data2;
    logic [K-1:0] out_data3;
    logic [3:0]   cur_sel;

    int checks = 0;
    int errors = 0;

    demux4_onehot #(.K(K)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .s         (s),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data0 (out_data0),
        .out_data1 (out_data1),
        .out_data2 (out_data2),
        .out_data3 (out_data3),
        .cur_sel   (cur_sel)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [K-1:0] lane_out(input int lane);
        case (lane)
            0:       return out_data0;
            1:       return out_data1;
            2:       return out_data2;
            default: return out_data3;
        endcase
    endfunction

    initial begin
        logic [3:0] exp_lane;

        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        s         = 4'b0000;
        out_ready = 4'b0000;
        #2;
        chk("rst_valid", 32'(out_valid), 32'h0);
        chk("rst_data0", 32'(out_data0), 32'h0);
        chk("rst_data3", 32'(out_data3), 32'h0);
        chk("rst_sel", 32'(cur_sel), 32'h1);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // Round-robin with every consumer ready
        out_ready = 4'b1111;
        in_valid  = 1'b1;
        s         = 4'b0000;
        for (int i = 1; i <= 5; i++) begin
            exp_lane = 4'b0001 << ((i - 1) % 4);
            in_data  = 8'(i);
            #1;
            chk("rr_ready", 32'(in_ready), 32'h1);
            chk("rr_sel", 32'(cur_sel), 32'(exp_lane));
            tick();
            chk("rr_valid", 32'(out_valid), 32'(exp_lane));
            chk("rr_data", 32'(lane_out((i - 1) % 4)), 32'(i));
        end

        // Backpressure: fill all lanes, then stall
        rst = 1'b1;
        #1;
        rst = 1'b0;
        out_ready = 4'b0000;
        for (int i = 0; i < 4; i++) begin
            in_data = 8'(8'hA + i);
            #1;
            chk("bp_fill_ready", 32'(in_ready), 32'h1);
            tick();
        end
        chk("bp_valid", 32'(out_valid), 32'hF);
        chk("bp_d0", 32'(out_data0), 32'hA);
        chk("bp_d1", 32'(out_data1), 32'hB);
        chk("bp_d2", 32'(out_data2), 32'hC);
        chk("bp_d3", 32'(out_data3), 32'hD);
        in_data = 8'hE;
        #1;
        chk("bp_stall_ready", 32'(in_ready), 32'h0);
        chk("bp_stall_sel", 32'(cur_sel), 32'h1);
        tick();
        chk("bp_hold_d0", 32'(out_data0), 32'hA);
        chk("bp_hold_valid", 32'(out_valid), 32'hF);
        out_ready = 4'b0001;
        #1;
        chk("bp_release_ready", 32'(in_ready), 32'h1);
        tick();
        in_valid = 1'b0;
        out_ready = 4'b0000;
        #1;
        chk("bp_d0_new", 32'(out_data0), 32'hE);
        chk("bp_valid_after", 32'(out_valid), 32'hF);
        chk("bp_ptr", 32'(cur_sel), 32'h2);

        // Steering priority; pointer is 0010 and must not move on steered transfers
        out_ready = 4'b1111;
        in_valid  = 1'b1;
        s         = 4'b0110;
        in_data   = 8'h7;
        #1;
        chk("st_sel_0110", 32'(cur_sel), 32'h2);
        chk("st_ready", 32'(in_ready), 32'h1);
        tick();
        chk("st_valid1", 32'(out_valid), 32'h2);
        chk("st_d1", 32'(out_data1), 32'h7);
        s       = 4'b1000;
        in_data = 8'h8;
        #1;
        chk("st_sel_1000", 32'(cur_sel), 32'h8);
        tick();
        chk("st_valid3", 32'(out_valid), 32'h8);
        chk("st_d3", 32'(out_data3), 32'h8);
        s       = 4'b0000;
        in_data = 8'h9;
        #1;
        chk("st_ptr_kept", 32'(cur_sel), 32'h2);
        tick();
        chk("st_rr_d1", 32'(out_data1), 32'h9);
        chk("st_rr_valid", 32'(out_valid), 32'h2);

        // Simultaneous drain and load on lane 2
        s       = 4'b0100;
        in_data = 8'h3;
        tick();
        chk("dl_pre_d2", 32'(out_data2), 32'h3);
        in_data = 8'h9;
        #1;
        chk("dl_ready", 32'(in_ready), 32'h1);
        tick();
        chk("dl_valid", 32'(out_valid), 32'h4);
        chk("dl_d2", 32'(out_data2), 32'h9);

        // Stall on busy steered target, then re-steer while stalled
        out_ready = 4'b0000;
        in_data   = 8'hF;
        #1;
        chk("rs_stall_ready", 32'(in_ready), 32'h0);
        s = 4'b0001;
        #1;
        chk("rs_sel", 32'(cur_sel), 32'h1);
        chk("rs_ready", 32'(in_ready), 32'h1);
        tick();
        chk("rs_d0", 32'(out_data0), 32'hF);
        chk("rs_hold_d2", 32'(out_data2), 32'h9);
        chk("rs_valid", 32'(out_valid), 32'h5);

        // Reset during traffic with three lanes valid
        s       = 4'b0010;
        in_data = 8'h6;
        tick();
        in_valid = 1'b0;
        s        = 4'b0000;
        chk("rt_pre_valid", 32'(out_valid), 32'h7);
        #3;
        rst = 1'b1;
        #1;
        chk("rt_valid", 32'(out_valid), 32'h0);
        chk("rt_d0", 32'(out_data0), 32'h0);
        chk("rt_d1", 32'(out_data1), 32'h0);
        chk("rt_d2", 32'(out_data2), 32'h0);
        chk("rt_sel", 32'(cur_sel), 32'h1);
        #2;
        rst       = 1'b0;
        out_ready = 4'b1111;
        in_valid  = 1'b1;
        in_data   = 8'h42;
        tick();
        in_valid = 1'b0;
        chk("rt_first_valid", 32'(out_valid), 32'h1);
        chk("rt_first_d0", 32'(out_data0), 32'h42);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
